run_detect_arbiter: RTL and testbench
=====================================

RUN_DETECT_ARBITER -- requirements
Module: run_detect_arbiter

Interface
REQ-001 Parameter RUN_LEN, default 4, is the number of consecutive equal sample pairs needed for a match; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  2  per-channel detection request; bit 0 = channel A, bit 1 = channel B; level-held by the requester.
REQ-005 a1, a2  input  1 each  channel A sample pair.
REQ-006 b1, b2  input  1 each  channel B sample pair.
REQ-007 gnt  output  2  one-hot grant; at most one bit high in any cycle.
REQ-008 busy  output  1  high while a detection window is in progress (state RUN).
REQ-009 done  output  1  single-cycle pulse marking a completed window.
REQ-010 z  output  1  window result: 1 = match, 0 = mismatch; registered and held until the next done.
REQ-011 done_id  output  1  channel that owns the completed window (0 = A, 1 = B); registered and held with z.

Function
REQ-012 The controller SHALL implement a three-state machine: IDLE, RUN, REPORT.
REQ-013 IDLE: with req == 0, the FSM stays in IDLE, with gnt = 0 and busy = 0.
REQ-014 IDLE: with any req bit high, the FSM selects a channel round-robin, registers gnt, and enters RUN on the next edge.
REQ-015 Round-robin: channel A has priority after reset; after each grant, the granted channel becomes lowest priority.
REQ-016 Simultaneous req = 2'b11 in IDLE: the higher-priority channel is granted, and the other waits (no loss, no starvation).
REQ-017 A single requesting channel is granted regardless of priority.
REQ-018 RUN: each cycle, the granted channel's pair is compared; the match counter (width 4, reset 0) increments when the two samples are equal.
REQ-019 RUN: the first unequal pair ends the window early and enters REPORT with result 0.
REQ-020 RUN: when the counter reaches RUN_LEN, the window ends and enters REPORT with result 1; the counter never exceeds RUN_LEN.
REQ-021 RUN: if the granted channel's req drops, the window is aborted: return to IDLE, no done, z and done_id unchanged, counter cleared.
REQ-022 A req change on the non-granted channel during RUN does not affect the active window.
REQ-023 REPORT: lasts exactly one cycle.
REQ-024 REPORT: done = 1; z and done_id are updated that cycle; gnt = 0; busy = 0; counter cleared.
REQ-025 REPORT: the FSM returns to IDLE, so there is at least one idle cycle between consecutive grants.
REQ-026 Latency with RUN_LEN = 4 and all pairs equal: req seen at edge 0 -> gnt high in cycles 1-4 -> done in cycle 5.
REQ-027 Latency for a mismatch on the first sampled pair: done in cycle 2 with z = 0.
REQ-028 Only registered outputs are driven; there are no combinational paths from inputs to outputs.

Reset
REQ-029 Asserting rst (low) at any time forces the following immediately, regardless of clk: state IDLE, gnt 0, busy 0, done 0, z 0, done_id 0, counter 0, priority to channel A.
REQ-030 Reset asserted mid-RUN discards the window with no done pulse.
REQ-031 After rst deasserts, the first arbitration occurs on the next rising edge with req high.

Verification
REQ-032 Channel A only, RUN_LEN 4, a1 == a2 for 4 cycles -> gnt = 01 in cycles 1-4, done in cycle 5, z = 1, done_id = 0.
REQ-033 Channel B only, b1 != b2 on the 3rd sample -> done in cycle 4, z = 0, done_id = 1, gnt dropped in cycle 4.
REQ-034 req = 11 held, all pairs equal -> grants alternate A, B, A; exactly one idle cycle between windows; done_id = 0, 1, 0.
REQ-035 Channel A granted, req[0] dropped after 2 equal samples -> return to IDLE, no done, z and done_id keep their prior values.
REQ-036 rst pulsed low mid-RUN, asynchronously to clk -> all outputs are 0 immediately; a later req = 11 grants channel A first.

Source files
------------

// File: rtl/run_detect_arbiter.sv
`timescale 1ns/1ps
// Two-channel round-robin arbiter that runs an equal-pair run detector on the granted channel.
// Each window reports match (z=1) after RUN_LEN equal pairs, or mismatch (z=0) on the first unequal pair.
module run_detect_arbiter #(
    parameter int unsigned RUN_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       a1,
    input  logic       a2,
    input  logic       b1,
    input  logic       b2,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       z,
    output logic       done_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [3:0] RUN_LEN_C = 4'(RUN_LEN);

    state_t     state_q;
    logic [1:0] gnt_q;
    logic       busy_q;
    logic       done_q;
    logic       z_q;
    logic       id_q;
    logic [3:0] cnt_q;
    logic       prio_q;   // 0: channel A wins a tie, 1: channel B wins a tie
    logic       own_q;    // channel owning the current window

    logic       pick_d;
    logic       pair_eq_d;
    logic       own_req_d;
    logic [3:0] cnt_d;

    assign pick_d    = (req == 2'b11) ? prio_q : req[1];
    assign pair_eq_d = own_q ? (b1 == b2) : (a1 == a2);
    assign own_req_d = req[own_q];
    assign cnt_d     = cnt_q + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= 4'd0;
            prio_q  <= 1'b0;
            own_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        own_q   <= pick_d;
                        gnt_q   <= pick_d ? 2'b10 : 2'b01;
                        prio_q  <= ~pick_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= 4'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Owner withdrawal takes precedence over any result this cycle.
                    if (!own_req_d) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        cnt_q   <= 4'd0;
                    end else if (!pair_eq_d) begin
                        state_q <= REPORT;
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        z_q     <= 1'b0;
                        id_q    <= own_q;
                    end else if (cnt_d == RUN_LEN_C) begin
                        state_q <= REPORT;
                        gnt_q   <= 2'b00;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        z_q     <= 1'b1;
                        id_q    <= own_q;
                        cnt_q   <= cnt_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                REPORT: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign z       = z_q;
    assign done_id = id_q;

endmodule

// File: tb/tb_run_detect_arbiter.sv
`timescale 1ns/1ps
// Directed bench for run_detect_arbiter (RUN_LEN = 4): latency, round-robin, abort and async reset.
module tb_run_detect_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic       a1, a2, b1, b2;
    logic [1:0] gnt;
    logic       busy, done, z, done_id;

    int n_checks = 0;
    int n_fail   = 0;

    run_detect_arbiter #(.RUN_LEN(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a1      (a1),
        .a2      (a2),
        .b1      (b1),
        .b2      (b2),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .z       (z),
        .done_id (done_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to 2 ns after the next rising edge, i.e. into the next cycle.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_gnt, input logic e_busy,
                           input logic e_done, input logic e_z, input logic e_id);
        chk({tag, " gnt"},     4'(gnt),     4'(e_gnt));
        chk({tag, " busy"},    4'(busy),    4'(e_busy));
        chk({tag, " done"},    4'(done),    4'(e_done));
        chk({tag, " z"},       4'(z),       4'(e_z));
        chk({tag, " done_id"}, 4'(done_id), 4'(e_id));
    endtask

    initial begin
        rst = 1'b0; req = 2'b00;
        a1 = 1'b0; a2 = 1'b0; b1 = 1'b0; b2 = 1'b0;
        #12;
        chk_all("reset held", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #11 rst = 1'b1;
        step();
        chk_all("idle no req", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Channel A alone, four equal pairs: match in cycle 5.
        req = 2'b01; a1 = 1'b1; a2 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk_all($sformatf("A run c%0d", c), 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_all("A report c5", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        req = 2'b00;
        step();
        chk_all("A after c6", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Channel B alone, third pair unequal: mismatch in cycle 4.
        req = 2'b10; b1 = 1'b0; b2 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk_all($sformatf("B run c%0d", c), 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
            if (c == 3) b2 = 1'b1;
        end
        step();
        chk_all("B report c4", 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        req = 2'b00; b2 = 1'b0;
        step();

        // Both held, all equal: A, B, A windows with REPORT + one IDLE cycle between.
        req = 2'b11; a1 = 1'b0; a2 = 1'b0; b1 = 1'b1; b2 = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            int w, p;
            logic [1:0] e_gnt;
            step();
            w = (c - 1) / 6;
            p = (c - 1) % 6;
            e_gnt = (p < 4) ? ((w % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("RR c%0d gnt", c), 4'(gnt), 4'(e_gnt));
            chk($sformatf("RR c%0d done", c), 4'(done), (p == 4) ? 4'd1 : 4'd0);
            if (p == 4) begin
                chk($sformatf("RR c%0d z", c), 4'(z), 4'd1);
                chk($sformatf("RR c%0d done_id", c), 4'(done_id), 4'(w % 2));
            end
        end
        req = 2'b00;
        step();

        // A granted, B rises mid-window (ignored), A drops after 2 samples: abort.
        req = 2'b01; a1 = 1'b1; a2 = 1'b1;
        step();
        chk_all("abort c1", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("abort c2", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        req = 2'b11;
        step();
        chk_all("abort c3 B rises", 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        req = 2'b10;
        step();
        chk_all("abort c4", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        // B still requesting: granted next, mismatch on its first pair.
        step();
        chk_all("B first c1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
        b1 = 1'b0; b2 = 1'b1;
        step();
        chk_all("B first c2", 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        req = 2'b00;
        step();

        // Async reset mid-RUN, then priority restored to A.
        req = 2'b01; a1 = 1'b0; a2 = 1'b0;
        step();
        step();
        chk_all("pre-rst run", 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_all("async rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        req = 2'b11; b1 = 1'b0; b2 = 1'b0;
        #2 rst = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk_all($sformatf("post-rst c%0d", c), 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_all("post-rst c5", 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        req = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
